bus_arbiter: RTL and testbench
==============================

// Module: bus_arbiter
// PURPOSE
//   Shares the single memory-bus master port between NUM_MASTERS requesters (USB PC link, N64 PI, CPU).
//   Round-robin grant, one outstanding transaction at a time.
//   Forwards the winner's request/write/bank/address/data downstream and routes busy/ack/read data back.
//   Sits between the bus masters and the SDRAM/flash/bank decoder.
// PARAMETERS
//   NUM_MASTERS     3     number of requesters, 2..8
//   TIMEOUT_CYCLES  1024  read-ack watchdog limit; used only with BUS_ARBITER_TIMEOUT_EN
// PORTS
//   i_clk          in   1        system clock
//   i_reset        in   1        synchronous, active-high reset
//   i_m_request    in   N        per-master request; held until accepted
//   i_m_write      in   N        per-master 1=write, 0=read
//   i_m_bank       in   4*N      per-master bank, master k at [4k+:4]
//   i_m_address    in   26*N     per-master byte address, master k at [26k+:26]
//   i_m_data       in   32*N     per-master write data, master k at [32k+:32]
//   o_m_busy       out  N        per-master: 0 = request accepted this cycle
//   o_m_ack        out  N        per-master read-data-valid pulse
//   o_m_data       out  32       read data, shared; valid with o_m_ack
//   o_grant        out  N        one-hot current owner; 0 in IDLE
//   o_timeout      out  1        1-cycle pulse on watchdog expiry (BUS_ARBITER_TIMEOUT_EN only, else 0)
//   o_request      out  1        downstream request
//   o_write        out  1        downstream write
//   o_bank         out  4        downstream bank
//   o_address      out  26       downstream address
//   o_data         out  32       downstream write data
//   i_busy         in   1        downstream stall; accept = o_request && !i_busy
//   i_ack          in   1        downstream read-data-valid pulse
//   i_data         in   32       downstream read data
// BEHAVIOUR
//   - States:
//     - IDLE:     no request driven.
//     - GRANT:    o_request=1, downstream fields registered from the winner and held stable.
//     - WAIT_ACK: read accepted; waiting for i_ack.
//   - Reset values: o_request=0, o_write=0, o_bank/o_address/o_data=0, o_grant=0, o_m_ack=0, o_timeout=0,
//     o_m_busy=all 1s, state IDLE, rr pointer=0.
//   - IDLE with any i_m_request:
//     - Winner = first set request searching upward from rr pointer, with wrap.
//     - Next cycle: state GRANT, o_request=1, fields latched, o_grant one-hot.
//     - Grant latency is 1 cycle.
//   - o_m_busy[k] = !(state==GRANT && o_grant[k] && !i_busy). It is combinational from i_busy.
//     Master accept therefore coincides with downstream accept.
//   - GRANT accept cycle:
//     - rr pointer <= winner+1, wrapping at NUM_MASTERS.
//     - o_request <= 0.
//     - Write: state <= IDLE.
//     - Read: state <= WAIT_ACK.
//   - The next grant can issue the cycle after returning to IDLE. Back-to-back writes reach 1 transfer per 2 cycles.
//   - WAIT_ACK on i_ack:
//     - o_m_ack[owner]=i_ack and o_m_data=i_data, combinational, same cycle.
//     - state <= IDLE, o_grant <= 0.
//   - i_ack in the GRANT accept cycle of a read: forwarded the same way; state goes directly to IDLE.
//   - i_ack in IDLE or in GRANT before accept: ignored; no o_m_ack.
//   - Request dropped by the owner while in GRANT: ignored. The latched transaction completes; masters must not withdraw.
//   - Reset mid-transaction: immediate return to reset values. The outstanding read is abandoned and a later stray i_ack is ignored.
//   - o_m_data = i_data at all times; only o_m_ack qualifies it.
// CONFIGURATION
//   - BUS_ARBITER_TIMEOUT_EN defined:
//     - 16-bit counter clears on entry to WAIT_ACK and increments each WAIT_ACK cycle.
//     - When the count reaches TIMEOUT_CYCLES-1 without i_ack: o_m_ack[owner]=1, o_m_data=32'hFFFF_FFFF, o_timeout=1 for 1 cycle, state IDLE.
//     - i_ack in that same cycle wins: real data, no o_timeout.
//   - BUS_ARBITER_TIMEOUT_EN undefined: no counter; WAIT_ACK waits indefinitely; o_timeout tied 0.
// TESTING
//   1. M0 writes addr 0x0000100, data 0xDEADBEEF, bank 1, i_busy=0 -> o_request high 1 cycle later with those fields; o_m_busy[0]=0 that cycle; IDLE next.
//   2. M0, M1, M2 request continuously with 3 writes each -> grant order 0,1,2,0,1,2,0,1,2; no master starved.
//   3. M1 read, i_busy=1 for 5 cycles, i_ack 3 cycles after accept with i_data=0x12345678 -> fields stable while busy; o_m_ack[1] pulses with 0x12345678; others 0.
//   4. M2 read pending in WAIT_ACK while M0 requests -> M0 not granted until the cycle after M2's ack.
//   5. i_reset asserted in WAIT_ACK, then i_ack -> all outputs at reset values; no o_m_ack.
//   6. [TIMEOUT_EN] TIMEOUT_CYCLES=8, read never acked -> o_m_ack and o_timeout after 8 WAIT_ACK cycles; o_m_data=0xFFFFFFFF.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - master-side and downstream bus signals of bus_arbiter
// slave = arbiter view, master = view of whatever drives the requesters and downstream side
interface bus_arbiter_if #(
  parameter int NUM_MASTERS = 3
);
  logic [NUM_MASTERS-1:0]    i_m_request;
  logic [NUM_MASTERS-1:0]    i_m_write;
  logic [4*NUM_MASTERS-1:0]  i_m_bank;
  logic [26*NUM_MASTERS-1:0] i_m_address;
  logic [32*NUM_MASTERS-1:0] i_m_data;
  logic [NUM_MASTERS-1:0]    o_m_busy;
  logic [NUM_MASTERS-1:0]    o_m_ack;
  logic [31:0]               o_m_data;
  logic [NUM_MASTERS-1:0]    o_grant;
  logic                      o_timeout;
  logic                      o_request;
  logic                      o_write;
  logic [3:0]                o_bank;
  logic [25:0]               o_address;
  logic [31:0]               o_data;
  logic                      i_busy;
  logic                      i_ack;
  logic [31:0]               i_data;

  modport slave (
    input  i_m_request, i_m_write, i_m_bank, i_m_address, i_m_data,
    input  i_busy, i_ack, i_data,
    output o_m_busy, o_m_ack, o_m_data, o_grant, o_timeout,
    output o_request, o_write, o_bank, o_address, o_data
  );

  modport master (
    output i_m_request, i_m_write, i_m_bank, i_m_address, i_m_data,
    output i_busy, i_ack, i_data,
    input  o_m_busy, o_m_ack, o_m_data, o_grant, o_timeout,
    input  o_request, o_write, o_bank, o_address, o_data
  );
endinterface

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin arbiter sharing one memory-bus master port, one transaction in flight
// Read-ack watchdog is built only when BUS_ARBITER_TIMEOUT_EN is defined.
module bus_arbiter #(
  parameter int NUM_MASTERS    = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic         i_clk,
  input  logic         i_reset,
  bus_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_MASTERS);

  typedef enum logic [1:0] {IDLE, GRANT, WAIT_ACK} state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       rr_q, rr_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic                   request_q, request_d;
  logic                   write_q, write_d;
  logic [3:0]             bank_q, bank_d;
  logic [25:0]            address_q, address_d;
  logic [31:0]            data_q, data_d;

  logic [IDX_W:0]         cand;
  logic [IDX_W-1:0]       winner;
  logic                   winner_valid;
  logic                   accept;
  logic                   ack_fwd;
  logic                   timeout_fire;

  // Descending scan so the candidate closest to the rr pointer is written last and wins.
  always_comb begin
    winner       = '0;
    winner_valid = 1'b0;
    cand         = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      cand = {1'b0, rr_q} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_MASTERS)) begin
        cand = cand - (IDX_W+1)'(NUM_MASTERS);
      end
      if (bus.i_m_request[cand[IDX_W-1:0]]) begin
        winner       = cand[IDX_W-1:0];
        winner_valid = 1'b1;
      end
    end
  end

  assign accept  = (state_q == GRANT) && !bus.i_busy;
  assign ack_fwd = bus.i_ack && ((state_q == WAIT_ACK) || (accept && !write_q));

`ifdef BUS_ARBITER_TIMEOUT_EN
  logic [15:0] wd_cnt_q, wd_cnt_d;

  // Cleared while granted so the first WAIT_ACK cycle counts as 0.
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (state_q == GRANT) begin
      wd_cnt_d = '0;
    end else if (state_q == WAIT_ACK) begin
      wd_cnt_d = wd_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end

  assign timeout_fire = (state_q == WAIT_ACK) && !bus.i_ack &&
                        (wd_cnt_q == 16'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_fire = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    owner_d   = owner_q;
    grant_d   = grant_q;
    request_d = request_q;
    write_d   = write_q;
    bank_d    = bank_q;
    address_d = address_q;
    data_d    = data_q;
    case (state_q)
      IDLE: begin
        if (winner_valid) begin
          state_d   = GRANT;
          request_d = 1'b1;
          owner_d   = winner;
          grant_d   = NUM_MASTERS'(1) << winner;
          write_d   = bus.i_m_write[winner];
          bank_d    = bus.i_m_bank[4*int'(winner) +: 4];
          address_d = bus.i_m_address[26*int'(winner) +: 26];
          data_d    = bus.i_m_data[32*int'(winner) +: 32];
        end
      end
      GRANT: begin
        if (accept) begin
          request_d = 1'b0;
          rr_d      = (owner_q == IDX_W'(NUM_MASTERS - 1)) ? '0 : owner_q + 1'b1;
          if (write_q || ack_fwd) begin
            state_d = IDLE;
            grant_d = '0;
          end else begin
            state_d = WAIT_ACK;
          end
        end
      end
      WAIT_ACK: begin
        if (ack_fwd || timeout_fire) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d   = IDLE;
        grant_d   = '0;
        request_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      owner_q   <= '0;
      grant_q   <= '0;
      request_q <= 1'b0;
      write_q   <= 1'b0;
      bank_q    <= '0;
      address_q <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      owner_q   <= owner_d;
      grant_q   <= grant_d;
      request_q <= request_d;
      write_q   <= write_d;
      bank_q    <= bank_d;
      address_q <= address_d;
      data_q    <= data_d;
    end
  end

  // Master accept is the downstream accept, so busy follows i_busy combinationally.
  assign bus.o_m_busy  = i_reset ? '1 : ~(accept ? grant_q : '0);
  assign bus.o_m_ack   = (!i_reset && (ack_fwd || timeout_fire)) ? grant_q : '0;
  assign bus.o_m_data  = timeout_fire ? 32'hFFFF_FFFF : bus.i_data;
  assign bus.o_timeout = timeout_fire && !i_reset;
  assign bus.o_grant   = grant_q;
  assign bus.o_request = request_q;
  assign bus.o_write   = write_q;
  assign bus.o_bank    = bank_q;
  assign bus.o_address = address_q;
  assign bus.o_data    = data_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed and randomized checks of bus_arbiter against a transaction-level model
module tb_bus_arbiter;
  localparam int N  = 3;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bus_arbiter_if #(.NUM_MASTERS(N)) bus ();
  bus_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // requester side: one pending transaction per master, held until the model says accepted
  bit          p_req  [N];
  bit          p_wr   [N];
  logic [3:0]  p_bank [N];
  logic [25:0] p_addr [N];
  logic [31:0] p_data [N];

  // reference: the single transaction currently owning the bus
  bit          m_active, m_acc;
  int          m_own, m_rr, m_wcnt;
  bit          m_write;
  logic [3:0]  m_bank;
  logic [25:0] m_addr;
  logic [31:0] m_data;
  int          grant_log[$];

  task automatic drive_inputs();
    for (int k = 0; k < N; k++) begin
      bus.i_m_request[k]         = p_req[k];
      bus.i_m_write[k]           = p_wr[k];
      bus.i_m_bank[4*k +: 4]     = p_bank[k];
      bus.i_m_address[26*k +: 26] = p_addr[k];
      bus.i_m_data[32*k +: 32]   = p_data[k];
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_acc = 0; m_own = 0; m_rr = 0; m_wcnt = 0;
    for (int k = 0; k < N; k++) p_req[k] = 0;
  endtask

  task automatic model_step();
    bit acc_now, done, tmo, found;
    logic [N-1:0] eg, eb, ea;
    acc_now = m_active && !m_acc && !bus.i_busy;
    done    = bus.i_ack && m_active && (m_acc || (acc_now && !m_write));
    tmo     = 0;
`ifdef BUS_ARBITER_TIMEOUT_EN
    tmo = m_active && m_acc && (m_wcnt == TO - 1) && !bus.i_ack;
`endif
    eg = '0;
    if (m_active) eg[m_own] = 1'b1;
    eb = acc_now ? ~eg : '1;
    ea = (done || tmo) ? eg : '0;
    check("grant",   bus.o_grant,   eg);
    check("request", bus.o_request, m_active && !m_acc);
    check("m_busy",  bus.o_m_busy,  eb);
    check("m_ack",   bus.o_m_ack,   ea);
    check("m_data",  bus.o_m_data,  tmo ? 32'hFFFF_FFFF : bus.i_data);
    check("timeout", bus.o_timeout, tmo);
    if (m_active && !m_acc) begin
      check("f_write", bus.o_write,   m_write);
      check("f_bank",  bus.o_bank,    m_bank);
      check("f_addr",  bus.o_address, m_addr);
      check("f_data",  bus.o_data,    m_data);
    end
    if (bus.o_request && !bus.i_busy)
      for (int k = 0; k < N; k++) if (bus.o_grant[k]) grant_log.push_back(k);

    if (!m_active) begin
      found = 0;
      for (int i = 0; i < N; i++) begin
        int k;
        k = (m_rr + i) % N;
        if (!found && p_req[k]) begin
          found = 1; m_active = 1; m_acc = 0; m_own = k;
          m_write = p_wr[k]; m_bank = p_bank[k]; m_addr = p_addr[k]; m_data = p_data[k];
        end
      end
    end else if (!m_acc) begin
      if (acc_now) begin
        m_rr = (m_own + 1) % N;
        p_req[m_own] = 0;
        if (m_write || done) m_active = 0;
        else begin m_acc = 1; m_wcnt = 0; end
      end
    end else begin
      if (done || tmo) m_active = 0;
      else m_wcnt++;
    end
  endtask

  // inputs change 1 unit after posedge; outputs compared at negedge
  task automatic cycle();
    drive_inputs();
    @(negedge clk);
    if (rst) model_reset();
    else model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; bus.i_busy = 0; bus.i_ack = 0;
    for (int k = 0; k < N; k++) p_req[k] = 0;
    cycle(); cycle();
    rst = 0;
  endtask

  task automatic load(input int k, input bit wr, input logic [3:0] bank,
                      input logic [25:0] addr, input logic [31:0] data);
    p_req[k] = 1; p_wr[k] = wr; p_bank[k] = bank; p_addr[k] = addr; p_data[k] = data;
  endtask

  task automatic settle();
    drive_inputs();
    #1;
  endtask

  initial begin
    int cnt [N];
    rst = 1;
    bus.i_busy = 0; bus.i_ack = 0; bus.i_data = '0;
    for (int k = 0; k < N; k++) load(k, 0, '0, '0, '0);
    for (int k = 0; k < N; k++) p_req[k] = 0;
    drive_inputs();
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    settle();
    check("rst_request", bus.o_request, 0);
    check("rst_grant",   bus.o_grant,   0);
    check("rst_busy",    bus.o_m_busy,  3'b111);
    check("rst_ack",     bus.o_m_ack,   0);
    check("rst_timeout", bus.o_timeout, 0);
    check("rst_write",   bus.o_write,   0);
    check("rst_bank",    bus.o_bank,    0);
    check("rst_addr",    bus.o_address, 0);
    check("rst_data",    bus.o_data,    0);

    // single write from M0
    load(0, 1, 4'd1, 26'h000_0100, 32'hDEAD_BEEF);
    cycle();
    settle();
    check("t1_request", bus.o_request, 1);
    check("t1_grant",   bus.o_grant,   3'b001);
    check("t1_write",   bus.o_write,   1);
    check("t1_bank",    bus.o_bank,    4'd1);
    check("t1_addr",    bus.o_address, 26'h000_0100);
    check("t1_data",    bus.o_data,    32'hDEAD_BEEF);
    check("t1_busy",    bus.o_m_busy,  3'b110);
    cycle();
    settle();
    check("t1_idle_req",   bus.o_request, 0);
    check("t1_idle_grant", bus.o_grant,   0);

    // round robin, all three masters requesting continuously
    do_reset();
    grant_log.delete();
    for (int k = 0; k < N; k++) cnt[k] = 0;
    for (int c = 0; c < 100 && grant_log.size() < 9; c++) begin
      for (int k = 0; k < N; k++)
        if (!p_req[k] && cnt[k] < 3) begin
          load(k, 1, 4'(k), 26'(c), $urandom);
          cnt[k]++;
        end
      cycle();
    end
    check("t2_count", grant_log.size(), 9);
    for (int i = 0; i < grant_log.size() && i < 9; i++) check("t2_order", grant_log[i], i % 3);

    // M1 read stalled 5 cycles, acked 3 cycles after accept
    load(1, 0, 4'd7, 26'h2AB_CDEF, 32'h0);
    bus.i_busy = 1;
    cycle();
    for (int i = 0; i < 5; i++) cycle();
    settle();
    check("t3_stable_addr", bus.o_address, 26'h2AB_CDEF);
    check("t3_stable_bank", bus.o_bank,    4'd7);
    check("t3_stall_busy",  bus.o_m_busy,  3'b111);
    bus.i_busy = 0;
    cycle();
    cycle(); cycle();
    bus.i_ack = 1; bus.i_data = 32'h1234_5678;
    settle();
    check("t3_ack",  bus.o_m_ack,  3'b010);
    check("t3_data", bus.o_m_data, 32'h1234_5678);
    cycle();
    bus.i_ack = 0;

    // M2 read outstanding blocks M0
    load(2, 0, 4'd2, 26'h10, 32'h0);
    cycle(); cycle();
    load(0, 1, 4'd3, 26'h20, 32'h5555_AAAA);
    for (int i = 0; i < 4; i++) begin
      settle();
      check("t4_grant_wait", bus.o_grant, 3'b100);
      cycle();
    end
    bus.i_ack = 1;
    settle();
    check("t4_ack", bus.o_m_ack, 3'b100);
    cycle();
    bus.i_ack = 0;
    settle();
    check("t4_idle", bus.o_grant, 0);
    cycle();
    settle();
    check("t4_m0_grant", bus.o_grant, 3'b001);
    cycle();

    // reset while waiting for a read ack, then a stray ack
    load(1, 0, 4'd4, 26'h30, 32'h0);
    cycle(); cycle();
    rst = 1;
    cycle();
    rst = 0; bus.i_ack = 1;
    settle();
    check("t5_ack",     bus.o_m_ack,   0);
    check("t5_grant",   bus.o_grant,   0);
    check("t5_request", bus.o_request, 0);
    check("t5_busy",    bus.o_m_busy,  3'b111);
    cycle();
    bus.i_ack = 0;

`ifdef BUS_ARBITER_TIMEOUT_EN
    load(0, 0, 4'd5, 26'h40, 32'h0);
    cycle(); cycle();
    for (int i = 0; i < TO; i++) begin
      settle();
      check("t6_timeout", bus.o_timeout, i == TO - 1);
      check("t6_ack",     bus.o_m_ack,   (i == TO - 1) ? 3'b001 : 3'b000);
      if (i == TO - 1) check("t6_data", bus.o_m_data, 32'hFFFF_FFFF);
      cycle();
    end
`endif

    // randomized traffic, stalls, stray and real acks
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++)
        if (!p_req[k] && $urandom_range(0, 99) < 40)
          load(k, 1'($urandom_range(0, 1)), 4'($urandom), 26'($urandom), $urandom);
      bus.i_busy = ($urandom_range(0, 99) < 30);
      bus.i_ack  = ($urandom_range(0, 99) < 25);
      bus.i_data = $urandom;
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
